// File: rtl/dbf_rx_sequencer.sv
// Per-frame TX/RX scheduler for the DBF channel array: TX burst, blanking, acquisition, gap per line.
// Optional DBF_LINE_OFFSET_EN: each line addresses its own delay-LUT region (line_idx*zones + z).
module dbf_rx_sequencer #(
  parameter int ADDR_WD       = 12,
  parameter int LINE_WD       = 7,
  parameter int LINES         = 128,
  parameter int TX_CYCLES     = 64,
  parameter int RX_DEAD       = 16,
  parameter int DEPTH_SAMPLES = 1024,
  parameter int ZONE_LEN      = 32,
  parameter int CNT_WD        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_go,
  input  logic               abort,
  output logic               tx_en,
  output logic               start,
  output logic [ADDR_WD-1:0] dbf_lut_addr,
  output logic               dbf_lut_we,
  output logic [LINE_WD-1:0] line_idx,
  output logic               line_done,
  output logic               frame_done,
  output logic               busy
);

  // state | meaning
  // IDLE  | waiting for frame_go
  // TX    | transmit burst, tx_en high
  // BLANK | receive blanking after the burst
  // ACQ   | acquisition, start high, LUT address steps per zone
  // GAP   | one-cycle line end, line_done pulse
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] TX    = 3'd1;
  localparam logic [2:0] BLANK = 3'd2;
  localparam logic [2:0] ACQ   = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  logic [2:0]         state;
  logic [CNT_WD-1:0]  cnt;
  logic [CNT_WD-1:0]  zcnt;
  logic [ADDR_WD-1:0] line_base;
  logic               last_line;

`ifdef DBF_LINE_OFFSET_EN
  localparam int ZONES = DEPTH_SAMPLES / ZONE_LEN;
  // Truncating both operands first gives the same low ADDR_WD bits as the full product.
  assign line_base = ADDR_WD'(line_idx) * ADDR_WD'(ZONES);
`else
  assign line_base = '0;
`endif

  assign last_line = (line_idx == LINE_WD'(LINES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      zcnt         <= '0;
      tx_en        <= 1'b0;
      start        <= 1'b0;
      dbf_lut_addr <= '0;
      dbf_lut_we   <= 1'b0;
      line_idx     <= '0;
      line_done    <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
    end else if (abort) begin
      state        <= IDLE;
      cnt          <= '0;
      zcnt         <= '0;
      tx_en        <= 1'b0;
      start        <= 1'b0;
      dbf_lut_addr <= '0;
      dbf_lut_we   <= 1'b0;
      line_idx     <= '0;
      line_done    <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      dbf_lut_we <= 1'b0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_go) begin
            state    <= TX;
            cnt      <= '0;
            line_idx <= '0;
            tx_en    <= 1'b1;
            busy     <= 1'b1;
          end
        end
        TX: begin
          if (cnt == CNT_WD'(TX_CYCLES - 1)) begin
            state <= BLANK;
            cnt   <= '0;
            tx_en <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BLANK: begin
          if (cnt == CNT_WD'(RX_DEAD - 1)) begin
            state        <= ACQ;
            cnt          <= '0;
            zcnt         <= '0;
            start        <= 1'b1;
            dbf_lut_we   <= 1'b1;
            dbf_lut_addr <= line_base;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACQ: begin
          if (cnt == CNT_WD'(DEPTH_SAMPLES - 1)) begin
            state      <= GAP;
            start      <= 1'b0;
            line_done  <= 1'b1;
            frame_done <= last_line;
          end else begin
            cnt <= cnt + 1'b1;
            if (zcnt == CNT_WD'(ZONE_LEN - 1)) begin
              zcnt         <= '0;
              dbf_lut_we   <= 1'b1;
              dbf_lut_addr <= dbf_lut_addr + 1'b1;
            end else begin
              zcnt <= zcnt + 1'b1;
            end
          end
        end
        GAP: begin
          cnt <= '0;
          if (last_line) begin
            state        <= IDLE;
            busy         <= 1'b0;
            line_idx     <= '0;
            dbf_lut_addr <= '0;
          end else begin
            state    <= TX;
            line_idx <= line_idx + 1'b1;
            tx_en    <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          tx_en <= 1'b0;
          start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbf_rx_sequencer.sv
// Directed-vector bench for dbf_rx_sequencer with a small frame (TX 4, blank 2, depth 16, zone 4, 2 lines).
module tb_dbf_rx_sequencer;

  logic        clk;
  logic        rst_n;
  logic        frame_go;
  logic        abort;
  logic        tx_en;
  logic        start;
  logic [11:0] dbf_lut_addr;
  logic        dbf_lut_we;
  logic [6:0]  line_idx;
  logic        line_done;
  logic        frame_done;
  logic        busy;

  dbf_rx_sequencer #(
    .ADDR_WD(12), .LINE_WD(7), .LINES(2), .TX_CYCLES(4), .RX_DEAD(2),
    .DEPTH_SAMPLES(16), .ZONE_LEN(4), .CNT_WD(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_go(frame_go), .abort(abort),
    .tx_en(tx_en), .start(start), .dbf_lut_addr(dbf_lut_addr), .dbf_lut_we(dbf_lut_we),
    .line_idx(line_idx), .line_done(line_done), .frame_done(frame_done), .busy(busy)
  );

`ifdef DBF_LINE_OFFSET_EN
  localparam logic [11:0] L1B = 12'd4;
`else
  localparam logic [11:0] L1B = 12'd0;
`endif

  typedef struct packed {
    logic        tx;
    logic        st;
    logic [11:0] addr;
    logic        we;
    logic [6:0]  line;
    logic        ld;
    logic        fd;
    logic        bsy;
  } out_t;

  typedef struct {
    logic  go;
    logic  ab;
    int    n;
    out_t  exp;
    string name;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ld_cnt = 0;
  int   fd_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (line_done)  ld_cnt <= ld_cnt + 1;
      if (frame_done) fd_cnt <= fd_cnt + 1;
    end
  end

  function automatic out_t mk(input logic tx, input logic st, input logic [11:0] addr, input logic we,
                              input logic [6:0] line, input logic ld, input logic fd, input logic bsy);
    out_t o;
    o = '{tx: tx, st: st, addr: addr, we: we, line: line, ld: ld, fd: fd, bsy: bsy};
    return o;
  endfunction

  task automatic step(input int n, input logic go, input logic ab);
    frame_go = go;
    abort    = ab;
    @(posedge clk);
    #1;
    frame_go = 1'b0;
    abort    = 1'b0;
    for (int i = 1; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string nm, input out_t exp);
    out_t act;
    act = mk(tx_en, start, dbf_lut_addr, dbf_lut_we, line_idx, line_done, frame_done, busy);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got tx=%b st=%b addr=%0d we=%b line=%0d ld=%b fd=%b busy=%b, want tx=%b st=%b addr=%0d we=%b line=%0d ld=%b fd=%b busy=%b",
               nm, act.tx, act.st, act.addr, act.we, act.line, act.ld, act.fd, act.bsy,
               exp.tx, exp.st, exp.addr, exp.we, exp.line, exp.ld, exp.fd, exp.bsy);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      step(tbl[i].n, tbl[i].go, tbl[i].ab);
      check({tag, "/", tbl[i].name}, tbl[i].exp);
    end
  endtask

  out_t zero;
  int   ld0;
  int   fd0;

  initial begin
    zero = '0;
    // One full frame; frame_go re-pulsed during line-0 acquisition must be ignored.
    tbl.push_back('{1'b1, 1'b0, 1,  mk(1,0,12'd0,0,7'd0,0,0,1),       "tx_first"});
    tbl.push_back('{1'b0, 1'b0, 3,  mk(1,0,12'd0,0,7'd0,0,0,1),       "tx_last"});
    tbl.push_back('{1'b0, 1'b0, 1,  mk(0,0,12'd0,0,7'd0,0,0,1),       "blank0"});
    tbl.push_back('{1'b0, 1'b0, 1,  mk(0,0,12'd0,0,7'd0,0,0,1),       "blank1"});
    tbl.push_back('{1'b0, 1'b0, 1,  mk(0,1,12'd0,1,7'd0,0,0,1),       "acq_entry_l0"});
    tbl.push_back('{1'b0, 1'b0, 1,  mk(0,1,12'd0,0,7'd0,0,0,1),       "acq_c1_l0"});
    tbl.push_back('{1'b1, 1'b0, 3,  mk(0,1,12'd1,1,7'd0,0,0,1),       "zone1_go_ignored"});
    tbl.push_back('{1'b0, 1'b0, 4,  mk(0,1,12'd2,1,7'd0,0,0,1),       "zone2_l0"});
    tbl.push_back('{1'b0, 1'b0, 4,  mk(0,1,12'd3,1,7'd0,0,0,1),       "zone3_l0"});
    tbl.push_back('{1'b0, 1'b0, 3,  mk(0,1,12'd3,0,7'd0,0,0,1),       "acq_last_l0"});
    tbl.push_back('{1'b0, 1'b0, 1,  mk(0,0,12'd3,0,7'd0,1,0,1),       "gap_l0"});
    tbl.push_back('{1'b0, 1'b0, 1,  mk(1,0,12'd3,0,7'd1,0,0,1),       "tx_l1"});
    tbl.push_back('{1'b0, 1'b0, 6,  mk(0,1,L1B,1,7'd1,0,0,1),         "acq_entry_l1"});
    tbl.push_back('{1'b0, 1'b0, 12, mk(0,1,L1B+12'd3,1,7'd1,0,0,1),   "zone3_l1"});
    tbl.push_back('{1'b0, 1'b0, 4,  mk(0,0,L1B+12'd3,0,7'd1,1,1,1),   "gap_l1_frame_done"});
    tbl.push_back('{1'b0, 1'b0, 1,  mk(0,0,12'd0,0,7'd0,0,0,0),       "idle_after_frame"});

    rst_n    = 1'b0;
    frame_go = 1'b0;
    abort    = 1'b0;
    #12;
    check("reset", zero);
    rst_n = 1'b1;

    ld0 = ld_cnt; fd0 = fd_cnt;
    run_table("frame1");
    check_int("frame1_frame_done_count", fd_cnt - fd0, 1);
    check_int("frame1_line_done_count", ld_cnt - ld0, 2);

    // Abort in acquisition cycle 5 of line 1.
    ld0 = ld_cnt; fd0 = fd_cnt;
    step(1, 1'b1, 1'b0);
    check("abort_frame_start", mk(1,0,12'd0,0,7'd0,0,0,1));
    step(34, 1'b0, 1'b0);
    check("abort_acq_c5_l1", mk(0,1,L1B+12'd1,0,7'd1,0,0,1));
    step(1, 1'b0, 1'b1);
    check("abort_next_cycle", zero);
    step(3, 1'b0, 1'b0);
    check("abort_stays_idle", zero);
    check_int("abort_line_done_count", ld_cnt - ld0, 1);
    check_int("abort_frame_done_count", fd_cnt - fd0, 0);
    step(1, 1'b1, 1'b1);
    check("abort_beats_go", zero);
    step(1, 1'b1, 1'b0);
    check("restart_after_abort", mk(1,0,12'd0,0,7'd0,0,0,1));
    step(1, 1'b0, 1'b1);
    check("abort_in_tx", zero);

    // Asynchronous reset while transmitting line 1.
    step(1, 1'b1, 1'b0);
    step(23, 1'b0, 1'b0);
    check("tx_l1_before_reset", mk(1,0,12'd3,0,7'd1,0,0,1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_tx", zero);
    @(negedge clk);
    rst_n = 1'b1;

    ld0 = ld_cnt; fd0 = fd_cnt;
    run_table("frame2");
    check_int("frame2_frame_done_count", fd_cnt - fd0, 1);
    check_int("frame2_line_done_count", ld_cnt - ld0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dbf_rx_sequencer.md
Name: dbf_rx_sequencer

Overview:
- Per-frame transmit/receive scheduler for the DBF channel array.
- Drives the shared `tx_en`, `start`, `dbf_lut_addr` and `dbf_lut_we` lines that fan out to every dbf_chNN instance.
- Steps each scan line through four phases: transmit burst, receive blanking, acquisition, one-cycle gap.
- During acquisition it advances the coarse/fine delay LUT address once per focal zone.

Parameters:
- ADDR_WD, 12, width of dbf_lut_addr (must match the channels).
- LINE_WD, 7, width of line_idx.
- LINES, 128, scan lines per frame (1..2^LINE_WD).
- TX_CYCLES, 64, cycles tx_en is held high per line (>=1).
- RX_DEAD, 16, blanking cycles after tx_en falls, before start rises (>=1).
- DEPTH_SAMPLES, 1024, acquisition cycles per line (start high).
- ZONE_LEN, 32, samples per focal zone. DEPTH_SAMPLES must be a multiple of ZONE_LEN.
- CNT_WD, 16, internal phase counter width.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- frame_go, input, 1, one-cycle pulse that starts a frame; ignored while busy.
- abort, input, 1, synchronous abort to IDLE.
- tx_en, output, 1, transmit window; channels treat ~tx_en as input valid.
- start, output, 1, acquisition window to all channels.
- dbf_lut_addr, output, ADDR_WD, delay LUT address.
- dbf_lut_we, output, 1, one-cycle LUT access strobe on each address update.
- line_idx, output, LINE_WD, current scan line.
- line_done, output, 1, one-cycle pulse at end of each line.
- frame_done, output, 1, one-cycle pulse after the last line.
- busy, output, 1, high in any state except IDLE.

Behaviour:
- **Reset.** On rst_n=0, asynchronously: state=IDLE, all counters 0, and all outputs 0 (tx_en, start, dbf_lut_addr, dbf_lut_we, line_idx, line_done, frame_done, busy).
- **Registered outputs.** All outputs are registered. No combinational path from any input to any output.
- **States:** IDLE, TX, BLANK, ACQ, GAP.
- **IDLE.**
  - frame_go=1 at edge N: state=TX, line_idx=0, busy=1, tx_en=1 from edge N.
- **TX.**
  - tx_en=1 for exactly TX_CYCLES cycles.
  - Then BLANK with tx_en=0.
- **BLANK.**
  - tx_en=0, start=0 for RX_DEAD cycles.
  - Then ACQ.
- **ACQ.**
  - start=1 for exactly DEPTH_SAMPLES cycles.
  - A zone counter z starts at 0 and increments every ZONE_LEN cycles.
  - dbf_lut_addr is updated in the same cycle as the ACQ entry and at each zone boundary.
  - dbf_lut_we=1 only in those update cycles, giving DEPTH_SAMPLES/ZONE_LEN strobes per line.
- **GAP (one cycle).**
  - start=0 and line_done=1.
  - If line_idx==LINES-1: frame_done=1 in the same cycle, then IDLE with busy=0.
  - Otherwise: line_idx+1, then TX.
- **dbf_lut_addr between strobes.** Holds its value. Returns to 0 in IDLE.
- **frame_go while busy:** ignored, no queueing.
- **abort=1 in any state:**
  - Next edge goes to IDLE with all outputs 0.
  - No line_done or frame_done pulse is generated.
  - abort takes priority over frame_go in the same cycle.
- **Mid-frame reset:** same as power-on reset. Channels see tx_en=0 and start=0 immediately.
- **Counters.** Each phase counter reloads on state entry. Terminal count is TX_CYCLES-1, RX_DEAD-1 or DEPTH_SAMPLES-1 respectively. No wrap beyond terminal count.

Optional Feature:
- Macro: DBF_LINE_OFFSET_EN.
- Defined: dbf_lut_addr = line_idx*(DEPTH_SAMPLES/ZONE_LEN) + z, truncated to ADDR_WD. Each line reads its own LUT region.
- Not defined: dbf_lut_addr = z. The LUT is rewritten per line externally.
- Timing of dbf_lut_we is identical in both builds.

Test Plan:
All scenarios use TX_CYCLES=4, RX_DEAD=2, DEPTH_SAMPLES=16, ZONE_LEN=4, LINES=2.

1. Reset then frame_go pulse:
   - tx_en high 4 cycles, low 2 cycles, then start high 16 cycles.
   - line_done in the following cycle.
   - 23 cycles per line.
2. Same frame, macro off:
   - dbf_lut_addr = 0,1,2,3 with dbf_lut_we pulses at ACQ cycles 0,4,8,12.
   - Line 1 repeats 0..3.
   - frame_done at cycle 46 after frame_go, with busy falling next.
3. Same frame, DBF_LINE_OFFSET_EN defined:
   - Line 0 addresses 0..3.
   - Line 1 addresses 4..7.
4. frame_go reasserted in ACQ of line 0:
   - Ignored; frame still ends after 2 lines with exactly one frame_done.
5. abort asserted in ACQ cycle 5 of line 1:
   - Next cycle: all outputs 0, state IDLE.
   - No line_done or frame_done.
   - A new frame_go restarts at line_idx=0.
6. rst_n pulled low during TX:
   - tx_en, busy and line_idx clear asynchronously without waiting for clk.
   - Normal frame after release.
